// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 tables, types and round/key-schedule helper functions
package aes_pkg;
  typedef logic [127:0] block_t;
  typedef logic [31:0] word_t;
  typedef block_t key_array_t [0:10];
  typedef enum logic [1:0] {IDLE, KEYEXP, ROUNDS, DONE} aes_state_e;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
  localparam logic [7:0] RCON [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  function automatic logic [7:0] sbox(input logic [7:0] b, input logic inv);
    return inv ? INV_SBOX[2047-8*int'(b) -: 8] : SBOX[2047-8*int'(b) -: 8];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction
  function automatic block_t sub_bytes(input block_t s, input logic inv);
    block_t r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8], inv);
    return r;
  endfunction
  // Byte 4c+j sits in row j, column c; rows rotate left (encrypt) or right (decrypt).
  function automatic block_t shift_rows(input block_t s, input logic inv);
    block_t r;
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++)
        r[127-8*(4*c+j) -: 8] = s[127-8*(4*((c + (inv ? 4 - j : j)) % 4) + j) -: 8];
    return r;
  endfunction
  function automatic block_t mix_columns(input block_t s, input logic inv);
    block_t r;
    logic [15:0] coef;
    logic [7:0] b;
    coef = inv ? 16'hebd9 : 16'h2311;
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++) begin
        b = '0;
        for (int k = 0; k < 4; k++)
          b = b ^ gmul(s[127-8*(4*c+(j+k)%4) -: 8], coef[15-4*k -: 4]);
        r[127-8*(4*c+j) -: 8] = b;
      end
    return r;
  endfunction
  function automatic block_t key_step(input block_t k, input logic [7:0] rc);
    word_t w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t = {sbox(w3[23:16], 1'b0), sbox(w3[15:8], 1'b0), sbox(w3[7:0], 1'b0),
         sbox(w3[31:24], 1'b0)} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction
endpackage

// File: rtl/aes_round.sv
// aes_round: one combinational AES encrypt or decrypt round
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] blk,
  input  logic [127:0] rk,
  input  logic         decrypt,
  input  logic         last,
  output logic [127:0] res
);
  block_t enc_sr, dec_ark;
  // Encrypt: Sub/Shift/Mix/AddKey; decrypt: InvShift/InvSub/AddKey/InvMix
  always_comb begin
    enc_sr = shift_rows(sub_bytes(blk, 1'b0), 1'b0);
    dec_ark = sub_bytes(shift_rows(blk, 1'b1), 1'b1) ^ rk;
    res = decrypt ? (last ? dec_ark : mix_columns(dec_ark, 1'b1))
                  : (last ? enc_sr : mix_columns(enc_sr, 1'b0)) ^ rk;
  end
endmodule

// File: rtl/aes_cipher_core.sv
// aes_cipher_core: iterative AES-128 encrypt/decrypt with cached key schedule
module aes_cipher_core
  import aes_pkg::*;
#(
  parameter int RPC = 1
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         AES_START,
  input  logic         AES_MODE,
  input  logic [127:0] AES_KEY,
  input  logic [127:0] AES_MSG_IN,
  output logic [127:0] AES_MSG_OUT,
  output logic         AES_DONE,
  output logic         AES_BUSY
);
  localparam logic [3:0] STEP = 4'(RPC);
  if (!(RPC == 1 || RPC == 2 || RPC == 5 || RPC == 10)) begin : g_bad_rpc
    $error("aes_cipher_core: RPC must be 1, 2, 5 or 10");
  end
  aes_state_e st, st_nxt;
  key_array_t rk;
  block_t key_q, msg_q, cached_key, kprev, blk, nk;
  block_t chain [0:RPC];
  logic mode_q, cache_valid, hit, last_step;
  logic [3:0] kcnt, rcnt;
  assign hit = cache_valid && AES_KEY == cached_key;
  assign last_step = rcnt + STEP == 4'd10;
  assign nk = key_step(kprev, RCON[kcnt]);
  assign chain[0] = blk;
  for (genvar j = 0; j < RPC; j++) begin : g_rnd
    logic [3:0] ri, ki;
    assign ri = rcnt + 4'(j + 1);
    assign ki = mode_q ? 4'd10 - ri : ri;
    aes_round u_round (
      .blk(chain[j]),
      .rk(rk[ki]),
      .decrypt(mode_q),
      .last(ri == 4'd10),
      .res(chain[j+1])
    );
  end
  // State register
  always_ff @(posedge CLK) begin
    if (RESET) st <= IDLE;
    else st <= st_nxt;
  end
  // Next state; DONE waits for START to drop before returning to IDLE
  always_comb begin
    st_nxt = st == IDLE   ? (AES_START ? (hit ? ROUNDS : KEYEXP) : IDLE)
           : st == KEYEXP ? (kcnt == 4'd10 ? ROUNDS : KEYEXP)
           : st == ROUNDS ? (last_step ? DONE : ROUNDS)
           : (AES_START ? DONE : IDLE);
    AES_BUSY = st == KEYEXP || st == ROUNDS;
    AES_DONE = st == DONE;
  end
  // Request capture, key expansion into the cache, round iteration and result
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cache_valid <= 1'b0;
      kcnt <= '0;
      rcnt <= '0;
      AES_MSG_OUT <= '0;
    end else begin
      if (st == IDLE && AES_START) begin
        key_q <= AES_KEY;
        msg_q <= AES_MSG_IN;
        mode_q <= AES_MODE;
        rcnt <= '0;
        if (hit) blk <= AES_MSG_IN ^ (AES_MODE ? rk[10] : rk[0]);
        else begin
          cache_valid <= 1'b0;
          rk[0] <= AES_KEY;
          kprev <= AES_KEY;
          kcnt <= 4'd1;
        end
      end
      if (st == KEYEXP) begin
        rk[kcnt] <= nk;
        kprev <= nk;
        kcnt <= kcnt == 4'd10 ? 4'd0 : kcnt + 4'd1;
        if (kcnt == 4'd10) begin
          cache_valid <= 1'b1;
          cached_key <= key_q;
          blk <= msg_q ^ (mode_q ? nk : rk[0]);
        end
      end
      if (st == ROUNDS) begin
        rcnt <= last_step ? 4'd0 : rcnt + STEP;
        if (last_step) AES_MSG_OUT <= chain[RPC];
        else blk <= chain[RPC];
      end
    end
  end
endmodule
